// File: rtl/radix4_booth_mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package radix4_booth_mul_pkg;

    // Operand width is tied to the 65-bit shifter: 2*WIDTH+1 == 65.
    localparam int WIDTH  = 32;
    localparam int N_ITER = WIDTH / 2;
    localparam int P_W    = 2 * WIDTH + 1;
    localparam int CNT_W  = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit selected from the low three bits of P.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } booth_digit_t;

    // Radix-4 Booth recoding of {q[i+1], q[i], q[i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] bits);
        booth_digit_t d;
        case (bits)
            3'b001, 3'b010: d = PM;
            3'b011:         d = P2M;
            3'b100:         d = N2M;
            3'b101, 3'b110: d = NM;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/radix4_booth_mul_if.sv
// Operation bus between a requester and the Booth multiplier.
//
// Handshake: the requester pulses op_start while op_busy is low; the
// multiplier accepts it on that rising edge (in IDLE or DONE), raises op_busy
// for exactly N_ITER cycles, then raises op_done and presents result until a
// new op_start or op_clear. op_clear aborts at any time and wins over
// op_start. dbg_state mirrors the controller state for observation.
interface radix4_booth_mul_if;
    import radix4_booth_mul_pkg::*;

    logic                 op_start;
    logic                 op_clear;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 op_busy;
    logic                 op_done;
    logic [2*WIDTH-1:0]   result;
    state_t               dbg_state;

    modport master (
        output op_start, op_clear, multiplicand, multiplier,
        input  op_busy, op_done, result, dbg_state
    );

    modport slave (
        input  op_start, op_clear, multiplicand, multiplier,
        output op_busy, op_done, result, dbg_state
    );

endinterface

// File: rtl/asr65.sv
// 65-bit arithmetic right shifter by 0..3 positions.
module asr65 (
    input  logic [64:0] d_in,
    input  logic [1:0]  shamt,
    output logic [64:0] d_out
);

    // Sign-filling shift of the full word.
    assign d_out = $signed(d_in) >>> shamt;

endmodule

// File: rtl/radix4_booth_enc.sv
// Booth encoder: maps P[2:0] and the latched multiplicand to the 34-bit
// signed multiple to add into the upper half of P.
module radix4_booth_enc
    import radix4_booth_mul_pkg::*;
(
    input  logic [2:0]        p_low,
    input  logic [WIDTH-1:0]  m,
    output logic [WIDTH+1:0]  multiple
);

    localparam logic [WIDTH+1:0] ONE = (WIDTH+2)'(1);

    logic [WIDTH+1:0] m1;
    logic [WIDTH+1:0] m2;

    // 34 bits are enough to hold +/-2M for any 32-bit M without overflow.
    assign m1 = {{2{m[WIDTH-1]}}, m};
    assign m2 = m1 << 1;

    // Select the multiple; negatives are formed as two's complement.
    always_comb begin
        multiple = '0;
        case (booth_decode(p_low))
            PM:      multiple = m1;
            P2M:     multiple = m2;
            NM:      multiple = ~m1 + ONE;
            N2M:     multiple = ~m2 + ONE;
            default: multiple = '0;
        endcase
    end

endmodule

// File: rtl/radix4_booth_mul.sv
// Sequential signed 32x32 radix-4 Booth multiplier, 16 iterations per product.
// P = {U[31:0], V[31:0], Xm1}; each iteration adds the Booth multiple to U and
// shifts P right arithmetically by two through the shared 65-bit shifter.
module radix4_booth_mul
    import radix4_booth_mul_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    radix4_booth_mul_if.slave       bus
);

    state_t             state;
    logic [P_W-1:0]     p;
    logic [WIDTH-1:0]   m_lat;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH+1:0]   multiple;
    logic [WIDTH+1:0]   sum;
    logic [P_W-1:0]     shift_in;
    logic [P_W-1:0]     shift_out;
    logic [P_W-1:0]     p_next;

    radix4_booth_enc u_enc (
        .p_low    (p[2:0]),
        .m        (m_lat),
        .multiple (multiple)
    );

    // U sign-extended to 34 bits plus the selected multiple.
    assign sum      = {{2{p[P_W-1]}}, p[P_W-1:WIDTH+1]} + multiple;
    assign shift_in = {sum[WIDTH-1:0], p[WIDTH:0]};

    asr65 u_asr (
        .d_in  (shift_in),
        .shamt (2'b10),
        .d_out (shift_out)
    );

    // The top two bits come from the 34-bit sum so an overflowing U
    // (e.g. M = -2^31 with digit -2M) keeps its true sign.
    always_comb begin
        p_next = shift_out;
        p_next[P_W-1:P_W-2] = sum[WIDTH+1:WIDTH];
    end

    // Controller, iteration counter and partial-product register.
    always_ff @(posedge clk) begin
        if (reset || bus.op_clear) begin
            state <= IDLE;
            p     <= '0;
            cnt   <= '0;
            m_lat <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.op_start) begin
                        p     <= {{WIDTH{1'b0}}, bus.multiplier, 1'b0};
                        m_lat <= bus.multiplicand;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N_ITER - 1)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_busy   = (state == RUN);
    assign bus.op_done   = (state == DONE);
    assign bus.result    = (state == DONE) ? p[P_W-1:1] : '0;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_radix4_booth_mul.sv
// Self-checking bench for radix4_booth_mul.
module tb_radix4_booth_mul;
    import radix4_booth_mul_pkg::*;

    logic clk;
    logic reset;

    radix4_booth_mul_if bus();

    radix4_booth_mul dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact signed product with 64-bit integers.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Driver: present operands with op_start for one edge. With sync=1 it
    // first moves to the next falling edge. Returns at the falling edge after
    // the start edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sync);
        if (sync) @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.op_start     = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        @(negedge clk);
        bus.op_start     = 1'b0;
    endtask

    // Wait (bounded) for op_done; edges counts rising edges after the start
    // edge, busy_n counts falling-edge samples with op_busy high.
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = bus.op_busy ? 1 : 0;
        while (!bus.op_done && edges < 40) begin
            @(negedge clk);
            edges++;
            if (bus.op_busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.op_start     = 1'b0;
        bus.op_clear     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.op_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.op_busy); end
        checks++; if (bus.op_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.op_done); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
    endtask

    task automatic test_basic();
        int edges, busy_n;
        logic [63:0] exp;
        logic [63:0] res;
        issue(32'd3, 32'd5, 1'b1);
        wait_done(edges, busy_n);
        exp = exp_q.pop_front();
        res = bus.result;
        checks++; if (edges !== 16) begin errors++; $display("FAIL basic_latency: got %0d edges want 16", edges); end
        checks++; if (busy_n !== 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 16", busy_n); end
        checks++; if (res !== 64'd15) begin errors++; $display("FAIL basic_result: got %h want %h", res, 64'd15); end
        checks++; if (res !== exp) begin errors++; $display("FAIL basic_model: got %h want %h", res, exp); end
        // DONE must hold the product while no new request arrives.
        repeat (3) @(negedge clk);
        checks++; if (bus.op_done !== 1'b1 || bus.result !== exp) begin
            errors++; $display("FAIL done_hold: done=%b result=%h want done=1 result=%h", bus.op_done, bus.result, exp);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic [63:0] vx[6];
        int edges, busy_n;
        logic [63:0] exp;
        va[0] = 32'hFFFF_FFF9; vb[0] = 32'h0000_0006; vx[0] = 64'hFFFF_FFFF_FFFF_FFD6;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vx[1] = 64'h4000_0000_0000_0000;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h8000_0000; vx[2] = 64'hC000_0000_8000_0000;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vx[3] = 64'd1;
        va[4] = 32'h7FFF_FFFF; vb[4] = 32'h7FFF_FFFF; vx[4] = 64'h3FFF_FFFF_0000_0001;
        va[5] = 32'h8000_0000; vb[5] = 32'h7FFF_FFFF; vx[5] = 64'hC000_0000_8000_0000;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], 1'b1);
            wait_done(edges, busy_n);
            exp = exp_q.pop_front();
            checks++; if (bus.result !== vx[i]) begin
                errors++; $display("FAIL vector_%0d: %h x %h got %h want %h", i, va[i], vb[i], bus.result, vx[i]);
            end
            checks++; if (bus.result !== exp) begin
                errors++; $display("FAIL vector_model_%0d: got %h want %h", i, bus.result, exp);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int edges, busy_n;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 30; i++) begin
            a = pick_operand();
            b = pick_operand();
            issue(a, b, 1'b1);
            wait_done(edges, busy_n);
            exp = exp_q.pop_front();
            checks++; if (edges !== 16) begin errors++; $display("FAIL random_latency_%0d: got %0d want 16", i, edges); end
            checks++; if (bus.result !== exp) begin
                errors++; $display("FAIL random_%0d: %h x %h got %h want %h", i, a, b, bus.result, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_n;
        logic [31:0] a, b;
        logic [63:0] exp;
        issue($urandom, $urandom, 1'b1);
        wait_done(edges, busy_n);
        exp = exp_q.pop_front();
        checks++; if (bus.result !== exp) begin errors++; $display("FAIL b2b_first: got %h want %h", bus.result, exp); end
        for (int i = 0; i < 4; i++) begin
            // Restart straight out of DONE, no IDLE gap.
            a = pick_operand();
            b = pick_operand();
            issue(a, b, 1'b0);
            wait_done(edges, busy_n);
            exp = exp_q.pop_front();
            checks++; if (edges !== 16) begin errors++; $display("FAIL b2b_latency_%0d: got %0d want 16", i, edges); end
            checks++; if (bus.result !== exp) begin
                errors++; $display("FAIL b2b_%0d: %h x %h got %h want %h", i, a, b, bus.result, exp);
            end
        end
    endtask

    task automatic test_clear();
        int edges, busy_n;
        logic [63:0] exp;
        issue(32'd9, 32'd11, 1'b1);
        exp_q.delete();
        repeat (8) @(negedge clk);
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
        checks++; if (bus.op_busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", bus.op_busy); end
        checks++; if (bus.op_done !== 1'b0) begin errors++; $display("FAIL clear_done: got %b want 0", bus.op_done); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL clear_result: got %h want 0", bus.result); end
        checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL clear_state: got %0d want %0d", bus.dbg_state, IDLE); end
        issue(32'd2, 32'd2, 1'b0);
        wait_done(edges, busy_n);
        exp = exp_q.pop_front();
        checks++; if (edges !== 16) begin errors++; $display("FAIL clear_restart_latency: got %0d want 16", edges); end
        checks++; if (bus.result !== 64'd4) begin errors++; $display("FAIL clear_restart_result: got %h want 4", bus.result); end
        checks++; if (bus.result !== exp) begin errors++; $display("FAIL clear_restart_model: got %h want %h", bus.result, exp); end
    endtask

    task automatic test_start_held();
        logic [63:0] exp;
        int early;
        logic [31:0] a, b;
        a = pick_operand();
        b = pick_operand();
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.op_start     = 1'b1;
        exp = ref_mul(a, b);
        early = 0;
        for (int e = 0; e < 16; e++) begin
            @(negedge clk);
            if (bus.op_done !== 1'b0 || bus.op_busy !== 1'b1) early++;
            // Operands wander during RUN; the latched values must be used.
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
            if (e == 15) bus.op_start = 1'b0;
        end
        // 16 samples above cover edges 0..15; one more edge reaches DONE.
        @(negedge clk);
        checks++; if (early !== 0) begin errors++; $display("FAIL held_run_window: %0d bad samples want 0", early); end
        checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", bus.op_done); end
        checks++; if (bus.result !== exp) begin errors++; $display("FAIL held_result: got %h want %h", bus.result, exp); end
    endtask

    task automatic test_reset_midrun();
        issue($urandom, $urandom, 1'b1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.op_busy !== 1'b0 || bus.op_done !== 1'b0 || bus.result !== 64'd0) begin
            errors++; $display("FAIL midrun_reset: busy=%b done=%b result=%h want 0 0 0", bus.op_busy, bus.op_done, bus.result);
        end
        checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL midrun_reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
        reset = 1'b0;
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_random();
        test_back_to_back();
        test_clear();
        test_start_held();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
